hamming32t26d_enc_stream: RTL
=============================

// Module: hamming32t26d_enc_stream
// PURPOSE
//  Streaming SECDED encoder: takes 26-bit data words over a valid/ready handshake.
//  Emits 32-bit Hamming codewords (5 check bits + overall parity) that the
//  hamming32t26d decoder corrects or flags.
//  Sits on the write side of protected storage/links in the SEU IP, ahead of RAM or CDC.
//  Registered output with a 2-entry skid buffer: full throughput, no combinational ready path in->out.
// PARAMETERS
//  DATA_W   26  data width (fixed; asserted under FORMAL)
//  N_CHECKB 5   Hamming check bits, overall parity excluded (fixed)
//  CNT_W    16  width of emitted-codeword counter
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        asynchronous reset, active-high
//  flush_i      in   1        sync clear of buffered words
//  data_i       in   DATA_W   data to encode
//  valid_i      in   1        data_i valid
//  ready_o      out  1        block can accept
//  hv_o         out  32       codeword; hv_o[0] = overall parity
//  valid_o      out  1        hv_o valid
//  ready_i      in   1        downstream accepts
//  cnt_o        out  CNT_W    codewords handed off (valid_o & ready_i), wraps
// BEHAVIOUR
//  Reset (async): occupancy EMPTY, valid_o=0, ready_o=1, hv_o=0, cnt_o=0.
//  Codeword layout:
//   - Check bits at positions 1,2,4,8,16.
//   - data[0..25] at positions 3,5,6,7,9..15,17..31 in ascending order.
//   - p(2^k) = XOR of data positions with index bit k set.
//   - hv[0] = ^hv[31:1], so the codeword has even parity.
//  Encoding is combinational on data_i and registered on accept (valid_i & ready_o).
//  Latency 1 cycle: a word accepted in cycle n is on hv_o with valid_o=1 in n+1.
//  Occupancy FSM:
//   - EMPTY -> ONE on accept.
//   - ONE -> TWO on accept without output handshake.
//   - ONE -> EMPTY on output handshake without accept.
//   - TWO -> ONE on output handshake; there is no accept in TWO.
//   - Simultaneous accept and output handshake keeps the state.
//  ready_o = (state!=TWO) & ~flush_i, decoded from registered state only, plus flush_i.
//  While valid_o=1 & ready_i=0, hv_o is held stable; the word is never overwritten.
//  Order is preserved: the skid entry moves to the output register on output handshake.
//  flush_i=1 -> state EMPTY and valid_o=0 next cycle; ready_o=0 during flush, so no word is lost silently.
//  cnt_o increments on every output handshake, wraps 2^CNT_W-1 -> 0; flush_i does not clear it.
//  Reset mid-transfer discards all buffered words immediately (async).
// CONFIGURATION
//  HAMMING_ENC_ERR_INJ_EN defined:
//   - Adds ports inj_arm_i (1), inj_mask_i (32) and inj_pending_o (1).
//   - Pulse inj_arm_i latches the mask and sets inj_pending_o.
//   - The next accepted word is stored as codeword ^ mask, then inj_pending_o clears.
//   - Arm while pending relatches the mask. Arm and accept in the same cycle applies the new mask to that word.
//   - Reset/flush clears pending.
//  Not defined: ports absent, codewords are always clean, no extra flops.
// STRUCTURE
//  Package hamming_pkg:
//   - DATA_W, N_CHECKB, CW_W=32.
//   - typedef data_t/cw_t.
//   - Function cw_t hamming_encode(data_t), shared by the bench reference model.
//  Sub-module hamming32t26d_enc_core: pure combinational data_t->cw_t using the package function.
//  The stream wrapper holds the FSM, 2 codeword registers, counter and injection logic.
//  FORMAL: assert DATA_W==26, N_CHECKB==5; hv_o stable while valid_o & ~ready_i.
// TESTING
//  1) data 26'h0000000 -> hv_o=32'h00000000; data 26'h0000001 -> 32'h0000000F; 26'h3FFFFFF -> 32'hFFFFFFFF.
//  2) Random 10k words, ready_i=1: 1-cycle latency, no bubbles. Feeding hv_o to the decoder -> data_o==data_i, ded_error_o=0.
//  3) ready_i low 5 cycles after 2 accepts -> ready_o=0, hv_o stable; release -> both words in order, cnt_o+=2.
//  4) flush_i with state TWO -> valid_o=0 next cycle, ready_o=0 during flush; cnt_o unchanged.
//  5) (ERR_INJ_EN) mask 32'h00000400, arm, send 26'h155 -> decoder corrects, ded=0. Mask 32'h00000006 -> ded_error_o=1. inj_pending_o clears after accept.
//  6) Assert rst_i while valid_o=1 -> valid_o=0 same cycle, cnt_o=0. Counter wrap with CNT_W=4: after 16 handshakes cnt_o=0.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, types, occupancy states and SECDED encode function
package hamming_pkg;

  localparam int DATA_W   = 26;
  localparam int N_CHECKB = 5;
  localparam int CW_W     = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CW_W-1:0]   cw_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Data fills every non-power-of-two position 3..31 in ascending order; bit 0 makes parity even.
  function automatic cw_t hamming_encode(input data_t d);
    cw_t  cw;
    int   j;
    logic p;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < N_CHECKB; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CW_W; pos++) begin
        if (((pos & (pos - 1)) != 0) && ((pos >> k) & 1) == 1) p = p ^ cw[pos];
      end
      cw[1 << k] = p;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming32t26d_enc_core.sv
// rtl/hamming32t26d_enc_core.sv - combinational 26-bit data to 32-bit SECDED codeword
module hamming32t26d_enc_core
  import hamming_pkg::*;
(
  input  data_t data,
  output cw_t   cw
);

  assign cw = hamming_encode(data);

endmodule

// File: rtl/hamming32t26d_enc_stream.sv
// rtl/hamming32t26d_enc_stream.sv - streaming SECDED encoder with 2-entry skid buffer
// Optional error injection when HAMMING_ENC_ERR_INJ_EN is defined.
module hamming32t26d_enc_stream
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [25:0]      data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [31:0]      hv_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o
`ifdef HAMMING_ENC_ERR_INJ_EN
  ,
  input  logic             inj_arm_i,
  input  logic [31:0]      inj_mask_i,
  output logic             inj_pending_o
`endif
);

  occ_e state;
  cw_t  skid_q;
  cw_t  enc_cw;
  cw_t  store_cw;
  logic accept;
  logic out_hs;

  hamming32t26d_enc_core u_core (
    .data (data_i),
    .cw   (enc_cw)
  );

  // Ready depends only on registered occupancy and flush, never on ready_i.
  assign ready_o = (state != OCC_TWO) & ~flush_i;
  assign accept  = valid_i & ready_o;
  assign out_hs  = valid_o & ready_i;

`ifdef HAMMING_ENC_ERR_INJ_EN
  cw_t  inj_mask_q;
  cw_t  inj_eff;

  // A same-cycle arm overrides the latched mask for the word being accepted.
  always_comb begin
    inj_eff = '0;
    if (inj_arm_i)          inj_eff = inj_mask_i;
    else if (inj_pending_o) inj_eff = inj_mask_q;
  end
  assign store_cw = enc_cw ^ inj_eff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inj_mask_q    <= '0;
      inj_pending_o <= 1'b0;
    end else begin
      if (inj_arm_i) inj_mask_q <= inj_mask_i;
      if (flush_i || accept) inj_pending_o <= 1'b0;
      else if (inj_arm_i)    inj_pending_o <= 1'b1;
    end
  end
`else
  assign store_cw = enc_cw;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= OCC_EMPTY;
      valid_o <= 1'b0;
      hv_o    <= '0;
      skid_q  <= '0;
      cnt_o   <= '0;
    end else begin
      if (out_hs) cnt_o <= cnt_o + CNT_W'(1);
      if (flush_i) begin
        state   <= OCC_EMPTY;
        valid_o <= 1'b0;
      end else begin
        case (state)
          OCC_EMPTY: begin
            if (accept) begin
              hv_o    <= store_cw;
              valid_o <= 1'b1;
              state   <= OCC_ONE;
            end
          end
          OCC_ONE: begin
            if (accept && out_hs) begin
              hv_o <= store_cw;
            end else if (accept) begin
              skid_q <= store_cw;
              state  <= OCC_TWO;
            end else if (out_hs) begin
              valid_o <= 1'b0;
              state   <= OCC_EMPTY;
            end
          end
          OCC_TWO: begin
            if (out_hs) begin
              hv_o  <= skid_q;
              state <= OCC_ONE;
            end
          end
          default: begin
            state   <= OCC_EMPTY;
            valid_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FORMAL
  always_ff @(posedge clk_i) begin
    assert (DATA_W == 26 && N_CHECKB == 5);
    if (!rst_i && !$past(rst_i) && !$past(flush_i) && $past(valid_o) && !$past(ready_i))
      assert (hv_o == $past(hv_o) && valid_o);
  end
`endif

endmodule
